// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types for the BCD frame collector and downstream checker.
//   BCD_W             - width of one BCD digit
//   bcd_t             - one BCD digit
//   is_bcd()          - true when the digit is a legal decimal value (0..9)
//   collector_state_t - collector FSM states
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } collector_state_t;

  function automatic logic is_bcd(input bcd_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// bcd_shift_reg: DIGITS-slot BCD digit shift register.
//   clk, rst_n  - clock, async active-low reset
//   i_shift_en  - shift all slots up by one, slot 0 loads i_din
//   i_clear     - zero every slot (wins over i_shift_en)
//   i_din       - digit entering slot 0
//   o_bcd       - packed slots, slot 0 in the low nibble
module bcd_shift_reg
  import bcd_pkg::*;
#(
  parameter int DIGITS = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_shift_en,
  input  logic                    i_clear,
  input  bcd_t                    i_din,
  output logic [BCD_W*DIGITS-1:0] o_bcd
);

  logic [DIGITS-1:0][BCD_W-1:0] r_slot;
  logic [DIGITS-1:0][BCD_W-1:0] w_next;

  for (genvar i = 0; i < DIGITS; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign w_next[i] = i_din;
    end else begin : g_body
      assign w_next[i] = r_slot[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_slot[i] <= '0;
      else if (i_clear)    r_slot[i] <= '0;
      else if (i_shift_en) r_slot[i] <= w_next[i];
    end
  end

  assign o_bcd = r_slot;

endmodule

// File: rtl/bcd_frame_collector.sv
// bcd_frame_collector: gathers a serial BCD digit stream (MSD first, framed
// by in_last) into a right-aligned, zero-padded parallel digit vector and
// holds it under a valid/ready handshake.
//   clk, rst_n                - clock, async active-low reset
//   in_valid/in_ready         - input digit handshake
//   in_digit, in_last         - digit and end-of-frame marker
//   out_valid/out_ready       - assembled frame handshake
//   out_bcd                   - packed digits, slot 0 = least significant
//   out_count                 - digits stored (saturates at DIGITS)
//   out_overflow              - frame carried more than DIGITS digits
//   out_bad_digit             - frame carried a digit of 10..15
module bcd_frame_collector
  import bcd_pkg::*;
#(
  parameter int DIGITS = 48,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BCD_W-1:0]        in_digit,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*DIGITS-1:0] out_bcd,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_overflow,
  output logic                    out_bad_digit
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);

  collector_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_bad_digit;

  logic w_accept;
  logic w_room;
  logic w_shift;
  logic w_release;

  assign w_accept  = in_valid && in_ready;
  assign w_room    = (r_count < CNT_MAX);
  assign w_shift   = w_accept && w_room;
  // Consumer taking the frame also empties the register for the next one,
  // which is what keeps unused upper slots at zero.
  assign w_release = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (w_accept && in_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_bad_digit <= 1'b0;
    end else if (w_release) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_bad_digit <= 1'b0;
    end else if (w_accept) begin
      // Past DIGITS the digit is dropped: the most significant digits win.
      if (w_room) r_count    <= r_count + 1'b1;
      else        r_overflow <= 1'b1;
      if (!is_bcd(in_digit)) r_bad_digit <= 1'b1;
    end
  end

  bcd_shift_reg #(
    .DIGITS (DIGITS)
  ) u_shift_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift_en (w_shift),
    .i_clear    (w_release),
    .i_din      (in_digit),
    .o_bcd      (out_bcd)
  );

  assign out_count     = r_count;
  assign out_overflow  = r_overflow;
  assign out_bad_digit = r_bad_digit;

endmodule

// File: tb/tb_bcd_frame_collector.sv
module tb_bcd_frame_collector;
  localparam int DIGITS = 48;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int VW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_digit = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VW-1:0]    out_bcd;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;
  logic             out_bad_digit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_frame_collector #(.DIGITS(DIGITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_digit      (in_digit),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bcd       (out_bcd),
    .out_count     (out_count),
    .out_overflow  (out_overflow),
    .out_bad_digit (out_bad_digit)
  );

  // Drive one beat, let it be accepted at the next edge, sample #1 after.
  task automatic send_beat(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 ||
        out_count !== '0 || out_overflow !== 1'b0 || out_bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b bcd=%h cnt=%0d ovf=%b bad=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, out_bcd, out_count, out_overflow, out_bad_digit);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [VW-1:0] exp;
    exp = '0;
    exp[11:0] = 12'h123;
    send_beat(4'd1, 1'b0);
    send_beat(4'd2, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    send_beat(4'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== exp ||
          out_count !== CNT_W'(3) || out_overflow !== 1'b0 || out_bad_digit !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold[%0d]: vld=%b rdy=%b bcd=%h cnt=%0d ovf=%b bad=%b, want 1 0 %h 3 0 0",
                 c, out_valid, in_ready, out_bcd, out_count, out_overflow, out_bad_digit, exp);
      end
      @(posedge clk); #1;
    end
    release_frame();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL basic_release: vld=%b rdy=%b bcd=%h cnt=%0d, want 0 1 0 0",
               out_valid, in_ready, out_bcd, out_count);
    end
  endtask

  task automatic test_single();
    logic [VW-1:0] exp;
    exp = '0;
    exp[3:0] = 4'd7;
    send_beat(4'd7, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_count !== CNT_W'(1) || out_bcd !== exp ||
        out_overflow !== 1'b0 || out_bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL single: vld=%b cnt=%0d bcd=%h ovf=%b bad=%b, want 1 1 %h 0 0",
               out_valid, out_count, out_bcd, out_overflow, out_bad_digit, exp);
    end
    release_frame();
  endtask

  task automatic test_overflow();
    logic [VW-1:0] exp;
    exp = '0;
    // Digits k=0..47 retained; slot i holds digit k=47-i.
    for (int i = 0; i < DIGITS; i++) exp[4*i +: 4] = 4'((47 - i) % 10);
    for (int k = 0; k < 50; k++) send_beat(4'(k % 10), k == 49);
    checks++;
    if (out_count !== CNT_W'(48) || out_overflow !== 1'b1 || out_bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flags: cnt=%0d ovf=%b bad=%b, want 48 1 0",
               out_count, out_overflow, out_bad_digit);
    end
    checks++;
    if (out_bcd[3:0] !== 4'd7 || out_bcd[VW-1 -: 4] !== 4'd0) begin
      errors++;
      $display("FAIL overflow_ends: slot0=%h slot47=%h, want 7 0",
               out_bcd[3:0], out_bcd[VW-1 -: 4]);
    end
    checks++;
    if (out_bcd !== exp) begin
      errors++; $display("FAIL overflow_vec: got %h want %h", out_bcd, exp);
    end
    release_frame();
  endtask

  task automatic test_bad_digit();
    logic [VW-1:0] exp;
    exp = '0;
    exp[11:0] = 12'h4C5;
    send_beat(4'd4, 1'b0);
    send_beat(4'hC, 1'b0);
    send_beat(4'd5, 1'b1);
    checks++;
    if (out_bad_digit !== 1'b1 || out_overflow !== 1'b0 || out_count !== CNT_W'(3) ||
        out_bcd[7:4] !== 4'hC || out_bcd !== exp) begin
      errors++;
      $display("FAIL bad_digit: bad=%b ovf=%b cnt=%0d bcd=%h, want 1 0 3 %h",
               out_bad_digit, out_overflow, out_count, out_bcd, exp);
    end
    release_frame();
    checks++;
    if (out_bad_digit !== 1'b0) begin
      errors++; $display("FAIL bad_digit_clear: got %b want 0", out_bad_digit);
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] exp;
    exp = '0;
    exp[3:0] = 4'd9;
    for (int k = 0; k < 10; k++) send_beat(4'(k + 1), 1'b0);
    checks++;
    if (out_count !== CNT_W'(10)) begin
      errors++; $display("FAIL areset_pre: cnt=%0d want 10", out_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 ||
        out_count !== '0 || out_overflow !== 1'b0 || out_bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL areset: rdy=%b vld=%b bcd=%h cnt=%0d ovf=%b bad=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, out_bcd, out_count, out_overflow, out_bad_digit);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(4'd9, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_count !== CNT_W'(1) || out_bcd !== exp ||
        out_overflow !== 1'b0 || out_bad_digit !== 1'b0) begin
      errors++;
      $display("FAIL areset_next: vld=%b cnt=%0d bcd=%h ovf=%b bad=%b, want 1 1 %h 0 0",
               out_valid, out_count, out_bcd, out_overflow, out_bad_digit, exp);
    end
    release_frame();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp_a, exp_b;
    exp_a = '0; exp_a[7:0] = 8'h38;
    exp_b = '0; exp_b[7:0] = 8'h62;
    in_valid = 1'b1;
    in_digit = 4'd3; in_last = 1'b0;
    @(posedge clk); #1;
    in_digit = 4'd8; in_last = 1'b1;
    @(posedge clk); #1;
    in_digit = 4'd6; in_last = 1'b0;   // in_valid stays high through HOLD
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== CNT_W'(2) || out_bcd !== exp_a) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: vld=%b rdy=%b cnt=%0d bcd=%h, want 1 0 2 %h",
                 c, out_valid, in_ready, out_count, out_bcd, exp_a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0 || out_bcd !== '0) begin
      errors++;
      $display("FAIL b2b_no_bypass: vld=%b rdy=%b cnt=%0d bcd=%h, want 0 1 0 0",
               out_valid, in_ready, out_count, out_bcd);
    end
    @(posedge clk); #1;
    checks++;
    if (out_count !== CNT_W'(1) || out_bcd[3:0] !== 4'd6) begin
      errors++;
      $display("FAIL b2b_first_accept: cnt=%0d slot0=%h, want 1 6", out_count, out_bcd[3:0]);
    end
    in_digit = 4'd2; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_count !== CNT_W'(2) || out_bcd !== exp_b) begin
      errors++;
      $display("FAIL b2b_second: vld=%b cnt=%0d bcd=%h, want 1 2 %h",
               out_valid, out_count, out_bcd, exp_b);
    end
    release_frame();
  endtask

  task automatic test_stray_ready();
    out_ready = 1'b1;
    send_beat(4'd5, 1'b0);
    out_ready = 1'b0;
    checks++;
    if (out_count !== CNT_W'(1) || out_bcd[3:0] !== 4'd5 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready: cnt=%0d slot0=%h vld=%b, want 1 5 0",
               out_count, out_bcd[3:0], out_valid);
    end
    send_beat(4'd1, 1'b1);
    release_frame();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_bad_digit();
    test_async_reset();
    test_back_to_back();
    test_stray_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
